// File: rtl/key_loader.sv
// Serial key loader: shifts a 32-bit key frame (33 with KEY_LOADER_PARITY_EN) into a shadow register and commits it to key_x/key_p.
// Latency: committed outputs change 2 cycles after the final accepted bit (SHIFT -> CHECK -> COMMIT).
// Backpressure: sdi_ready is high only in SHIFT; MAX_FAIL consecutive parity failures lock the block until rst_n.
module key_loader #(
    parameter int MAX_FAIL = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        sdi,
    input  logic        sdi_valid,
    output logic        sdi_ready,
    output logic [27:0] key_x,
    output logic [3:0]  key_p,
    output logic        key_ok,
    output logic        load_err,
    output logic        locked_out,
    output logic        busy
);

`ifdef KEY_LOADER_PARITY_EN
    localparam int FRAME_BITS = 33;
`else
    localparam int FRAME_BITS = 32;
`endif
    localparam int          FW       = $clog2(MAX_FAIL + 1);
    localparam logic [5:0]  LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [FW:0] FAIL_LIM = (FW + 1)'(MAX_FAIL);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, COMMIT, LOCKOUT} state_t;

    state_t          state, state_nxt;
    logic [31:0]     shadow;
    logic [5:0]      bit_cnt;
    logic [FW-1:0]   fail_cnt;
    logic [FW:0]     fail_inc;
    logic            check_pass;
    logic            lock_hit;
    logic            take_bit;

`ifdef KEY_LOADER_PARITY_EN
    logic            par_bit;
    // Even parity across all 33 frame bits.
    assign check_pass = ~(^{par_bit, shadow});
`else
    assign check_pass = 1'b1;
`endif

    assign fail_inc = {1'b0, fail_cnt} + 1'b1;
    assign lock_hit = (fail_inc >= FAIL_LIM);
    // A restart request in the same cycle discards the offered bit.
    assign take_bit = (state == SHIFT) && sdi_valid && !load_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sdi_ready  = 1'b0;
        busy       = 1'b0;
        locked_out = 1'b0;
        load_err   = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = SHIFT;
            end
            SHIFT: begin
                sdi_ready = 1'b1;
                busy      = 1'b1;
                if (take_bit && (bit_cnt == LAST_BIT)) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (check_pass) begin
                    state_nxt = COMMIT;
                end else begin
                    load_err  = 1'b1;
                    state_nxt = lock_hit ? LOCKOUT : IDLE;
                end
            end
            COMMIT: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            LOCKOUT: begin
                locked_out = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            bit_cnt  <= '0;
            fail_cnt <= '0;
            key_x    <= '0;
            key_p    <= '0;
            key_ok   <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, SHIFT: begin
                    if (load_start) begin
                        shadow  <= '0;
                        bit_cnt <= '0;
`ifdef KEY_LOADER_PARITY_EN
                        par_bit <= 1'b0;
`endif
                    end else if (take_bit) begin
                        if (!bit_cnt[5]) begin
                            shadow[bit_cnt[4:0]] <= sdi;
                        end
`ifdef KEY_LOADER_PARITY_EN
                        else begin
                            par_bit <= sdi;
                        end
`endif
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                CHECK: begin
                    if (!check_pass) begin
                        fail_cnt <= lock_hit ? FW'(MAX_FAIL) : fail_inc[FW-1:0];
                        if (lock_hit) begin
                            key_x  <= '0;
                            key_p  <= '0;
                            key_ok <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    key_x    <= shadow[27:0];
                    key_p    <= shadow[31:28];
                    key_ok   <= 1'b1;
                    fail_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader: table of key frames plus restart, reset, idle-input and lockout sequences.
module tb_key_loader;

`ifdef KEY_LOADER_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 33;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 32;
`endif
    localparam int MAX_FAIL = 3;

    logic        clk = 1'b0;
    logic        rst_n, load_start, sdi, sdi_valid;
    logic        sdi_ready, key_ok, load_err, locked_out, busy;
    logic [27:0] key_x;
    logic [3:0]  key_p;

    always #5 clk = ~clk;

    key_loader #(.MAX_FAIL(MAX_FAIL)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .sdi(sdi),
        .sdi_valid(sdi_valid), .sdi_ready(sdi_ready), .key_x(key_x),
        .key_p(key_p), .key_ok(key_ok), .load_err(load_err),
        .locked_out(locked_out), .busy(busy)
    );

    typedef struct {
        logic [27:0] x;
        logic [3:0]  p;
        logic        ok;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] k;
        bit          flip;
        logic [27:0] exp_x;
        logic [3:0]  exp_p;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[8];
    int          total = 0;
    int          bad   = 0;
    logic [27:0] m_x;
    logic [3:0]  m_p;
    logic        m_ok;
    int          m_fail;
    bit          m_lock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = '0; m_p = '0; m_ok = 1'b0; m_fail = 0; m_lock = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Bits go out LSB first with random idle gaps where sdi is junk.
    task automatic send_bits(input logic [32:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                sdi_valid = 1'b0;
                sdi = 1'($urandom);
                @(negedge clk);
            end
            sdi = f[i];
            sdi_valid = 1'b1;
            @(negedge clk);
        end
        sdi_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] k, input bit flip, input logic [27:0] tx,
                             input logic [3:0] tp, input logic terr, input bit do_start,
                             input bit ls_in_check);
        logic [32:0] f;
        exp_t e, mid;
        f = {(^k) ^ flip, k};
        mid.x = m_x; mid.p = m_p; mid.ok = m_ok; mid.err = 1'b0;
        e.err = terr;
        if (!terr) begin
            m_x = tx; m_p = tp; m_ok = 1'b1; m_fail = 0;
        end else begin
            m_fail++;
            if (m_fail >= MAX_FAIL) begin
                m_lock = 1'b1; m_x = '0; m_p = '0; m_ok = 1'b0;
                mid.x = '0; mid.p = '0; mid.ok = 1'b0;
            end
        end
        e.x = m_x; e.p = m_p; e.ok = m_ok;
        sb.push_back(e);
        if (do_start) start();
        send_bits(f, NB);
        chk("check_load_err", 32'(load_err), 32'(terr));
        chk("check_busy", 32'(busy), 32'd1);
        chk("check_sdi_ready", 32'(sdi_ready), 32'd0);
        if (ls_in_check) load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("hold_key_x", 32'(key_x), 32'(mid.x));
        chk("hold_key_p", 32'(key_p), 32'(mid.p));
        chk("hold_key_ok", 32'(key_ok), 32'(mid.ok));
        chk("hold_load_err", 32'(load_err), 32'd0);
        chk("locked_out", 32'(locked_out), 32'(m_lock));
        @(negedge clk);
        e = sb.pop_front();
        chk("key_x", 32'(key_x), 32'(e.x));
        chk("key_p", 32'(key_p), 32'(e.p));
        chk("key_ok", 32'(key_ok), 32'(e.ok));
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_key_x"}, 32'(key_x), 32'd0);
        chk({tag, "_key_p"}, 32'(key_p), 32'd0);
        chk({tag, "_key_ok"}, 32'(key_ok), 32'd0);
        chk({tag, "_load_err"}, 32'(load_err), 32'd0);
        chk({tag, "_locked_out"}, 32'(locked_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sdi_ready"}, 32'(sdi_ready), 32'd0);
    endtask

    initial begin
        vt[0] = '{32'hA5A55A5A, 1'b0, 28'h5A55A5A, 4'hA, 1'b0};
        vt[1] = '{32'hA5A55A5A, 1'b1, 28'h5A55A5A, 4'hA, PAR};
        vt[2] = '{32'hFFFFFFFF, 1'b0, 28'hFFFFFFF, 4'hF, 1'b0};
        vt[3] = '{32'h00000001, 1'b1, 28'h0000001, 4'h0, PAR};
        vt[4] = '{32'h00000001, 1'b1, 28'h0000001, 4'h0, PAR};
        vt[5] = '{32'h12345678, 1'b0, 28'h2345678, 4'h1, 1'b0};
        vt[6] = '{32'h80000000, 1'b0, 28'h0000000, 4'h8, 1'b0};
        vt[7] = '{32'h00000000, 1'b0, 28'h0000000, 4'h0, 1'b0};

        rst_n = 1'b0; load_start = 1'b0; sdi = 1'b0; sdi_valid = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(vt[i].k, vt[i].flip, vt[i].exp_x, vt[i].exp_p, vt[i].exp_err, 1'b1, (i == 2));
        end

        // Valid data in IDLE must not be taken or disturb the key.
        sdi_valid = 1'b1; sdi = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_sdi_ready", 32'(sdi_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        sdi_valid = 1'b0;
        chk("idle_key_x", 32'(key_x), 32'(m_x));

        // Restart after 10 bits; the bit offered with load_start is dropped.
        start();
        send_bits(33'({$urandom(), $urandom()}), 10);
        sdi = 1'b1; sdi_valid = 1'b1; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; sdi_valid = 1'b0;
        chk("restart_sdi_ready", 32'(sdi_ready), 32'd1);
        run_frame(32'h00000001, 1'b0, 28'h0000001, 4'h0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame.
        start();
        send_bits(33'({$urandom(), $urandom()}), 20);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'(busy), 32'd0);
        run_frame(32'h3C96E10F, 1'b0, 28'hC96E10F, 4'h3, 1'b0, 1'b1, 1'b0);

`ifdef KEY_LOADER_PARITY_EN
        for (int i = 0; i < MAX_FAIL; i++) begin
            run_frame(32'hA5A55A5A, 1'b1, 28'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        end
        start();
        chk("lock_sdi_ready", 32'(sdi_ready), 32'd0);
        chk("lock_busy", 32'(busy), 32'd0);
        chk("lock_locked_out", 32'(locked_out), 32'd1);
        chk("lock_key_x", 32'(key_x), 32'd0);
        rst_n = 1'b0;
        #1;
        check_all_zero("unlock");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(32'hA5A55A5A, 1'b0, 28'h5A55A5A, 4'hA, 1'b0, 1'b1, 1'b0);
`endif

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 The block SHALL have parameter MAX_FAIL, default 3, giving the consecutive failed loads that cause permanent lockout (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port load_start, input, 1 bit: single-cycle request to begin a key frame.
REQ-005 The block SHALL have port sdi, input, 1 bit: serial key data, LSB first.
REQ-006 The block SHALL have port sdi_valid, input, 1 bit: sdi holds a valid bit.
REQ-007 The block SHALL have port sdi_ready, output, 1 bit: block accepts a bit this cycle.
REQ-008 The block SHALL have port key_x, output, 28 bits: XOR key bits; bit i-1 drives X_i of the locked netlist.
REQ-009 The block SHALL have port key_p, output, 4 bits: MUX key bits; bit i-1 drives p_i of the locked netlist.
REQ-010 The block SHALL have port key_ok, output, 1 bit: a committed key is applied.
REQ-011 The block SHALL have port load_err, output, 1 bit: one-cycle pulse on a rejected frame.
REQ-012 The block SHALL have port locked_out, output, 1 bit: lockout reached.
REQ-013 The block SHALL have port busy, output, 1 bit: frame in progress (SHIFT or CHECK or COMMIT).

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, CHECK, COMMIT, LOCKOUT; sdi_ready SHALL be 1 only in SHIFT.
REQ-015 In IDLE, load_start=1 SHALL move the FSM to SHIFT and clear the shadow register and bit counter.
REQ-016 In SHIFT, a bit SHALL be accepted only when sdi_valid&&sdi_ready; accepted bit n (0..31) SHALL land in shadow K[n]; key_x=K[27:0], key_p=K[31:28].
REQ-017 After the final frame bit is accepted (bit 31, or bit 32 when parity is enabled), the FSM SHALL enter CHECK for exactly one cycle.
REQ-018 CHECK pass SHALL go to COMMIT; in COMMIT, key_x/key_p SHALL load from the shadow, key_ok SHALL set, the fail counter SHALL clear, and the FSM SHALL return to IDLE.
REQ-019 Committed outputs SHALL change exactly 2 cycles after the final accepted bit; key outputs SHALL NOT change at any other time except reset and lockout.
REQ-020 CHECK fail SHALL pulse load_err for one cycle, increment the saturating fail counter (width clog2(MAX_FAIL+1)), leave key_x/key_p/key_ok unchanged, and go to IDLE; if the counter reaches MAX_FAIL, the FSM SHALL go to LOCKOUT instead.
REQ-021 In LOCKOUT: key_x=0, key_p=0, key_ok=0, locked_out=1, sdi_ready=0, load_start ignored; exit SHALL be by rst_n only.
REQ-022 load_start in SHIFT SHALL restart the frame (counter and shadow cleared), discard any bit accepted that same cycle, and not count as a failure.
REQ-023 load_start in CHECK or COMMIT SHALL be ignored.
REQ-024 sdi_valid outside SHIFT SHALL be ignored.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE: key_x=0, key_p=0, key_ok=0, load_err=0, locked_out=0, busy=0, sdi_ready=0, fail counter=0, shadow=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; deassertion SHALL resume in IDLE.

Configuration
REQ-027 With KEY_LOADER_PARITY_EN defined, the frame SHALL be 33 bits, bit 32 being even parity (total ones across 33 bits even); CHECK SHALL fail on mismatch.
REQ-028 Without KEY_LOADER_PARITY_EN, the frame SHALL be 32 bits and CHECK SHALL always pass; load_err SHALL stay 0 and locked_out SHALL stay 0.

Verification
REQ-029 (parity on) Frame K=0xA5A55A5A, parity 0 -> 2 cycles after last bit: key_x=0x5A55A5A, key_p=0xA, key_ok=1, load_err=0.
REQ-030 (parity on) Same K with parity 1 -> load_err pulses once; key_x/key_p/key_ok retain prior values.
REQ-031 (parity on, MAX_FAIL=3) Three consecutive bad frames -> after the third, locked_out=1, key_x=0, key_p=0, key_ok=0; a following load_start -> sdi_ready stays 0.
REQ-032 load_start after 10 bits, then full frame K=0x00000001 with correct parity -> key_x=0x0000001, key_p=0x0; no load_err.
REQ-033 rst_n low for 1 cycle after 20 bits of a frame -> all outputs 0, FSM in IDLE; a new full frame commits normally.
REQ-034 (parity off) 32-bit frame K=0xFFFFFFFF -> key_x=0xFFFFFFF, key_p=0xF, key_ok=1 two cycles after bit 31.
